// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core pipeline.
// Fetch buffer entry layout and default depth.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_BUF_DEPTH = 4;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction FIFO between fetch and decode. No bypass in either direction.
// Flush (taken branch) empties the buffer and wins over push and pop.
module fetch_buffer
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  bus32_t                   pc_i,
  input  instruction_t             instr_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output bus32_t                   pc_o,
  output instruction_t             instr_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Handshakes look only at registered occupancy, so nothing passes straight through.
  assign ready_o = (count != FULL_COUNT);
  assign valid_o = (count != '0) & ~flush_i;
  assign push    = valid_i & ready_o & ~flush_i;
  assign pop     = valid_o & ready_i;

  assign pc_o    = mem[rd_ptr].pc;
  assign instr_o = mem[rd_ptr].instr;
  assign count_o = count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
